// File: rtl/rv32i_pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard/redirect controller:
// FSM encodings, reset polarity, register-index constants and a saturating increment.
package rv32i_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LUSE  = 2'd1,
    ST_MWAIT = 2'd2,
    ST_RDIR  = 2'd3
  } ctrl_state_e;

  localparam logic RESET_ACTIVE = 1'b1;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  localparam int unsigned FLUSH_CNT_W = 3;
  localparam int unsigned TMO_CNT_W   = 16;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rv32i_hazard_detect.sv
// Load-use compare: flags an ID instruction that reads the register a load in EX
// is about to write. x0 never creates a hazard since it is hardwired to zero.
module rv32i_hazard_detect
  import rv32i_pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_read,
  input  logic                 id_rs2_read,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_read && (id_rs1 == ex_rd);
  assign rs2_match = id_rs2_read && (id_rs2 == ex_rd);
  assign load_use  = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline hazard and redirect controller: Mealy PC/pipeline strobes with priority
// mem_busy > redirect > load-use, plus saturating statistics and sticky error flags.
//
//   state | meaning
//   RUN   | normal issue
//   LUSE  | load-use bubble just inserted; evaluates like RUN
//   MWAIT | data memory was busy; evaluates like RUN once it is ready
//   RDIR  | post-redirect IF/ID flush window, flush_rem_q cycles left
module rv32i_pipe_ctrl
  import rv32i_pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_read,
  input  logic                 id_rs2_read,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic [ADDR_W-1:0]    ex_branch_offset,
  input  logic                 ex_jump,
  input  logic [ADDR_W-1:0]    ex_jump_target,
  input  logic                 mem_busy,
  input  logic                 err_clr,
  output logic                 pc_stall,
  output logic                 pc_branch,
  output logic                 pc_jump,
  output logic [ADDR_W-1:0]    pc_offset,
  output logic [ADDR_W-1:0]    pc_jump_pc,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt,
  output logic [1:0]           err
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0]   TMO_RELOAD   = TMO_CNT_W'(MEM_TIMEOUT);

  ctrl_state_e            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_rem_q, flush_rem_d;
  logic [TMO_CNT_W-1:0]   tmo_left_q, tmo_left_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;
  logic [31:0]            flush_cnt_q, flush_cnt_d;
  logic [1:0]             err_q, err_d;
  logic [1:0]             err_set;
  logic                   rst_act;
  logic                   redirect;
  logic                   load_use;

  assign rst_act  = (rst == RESET_ACTIVE);
  assign redirect = ex_branch_taken || ex_jump;

  rv32i_hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_read (id_rs1_read),
    .id_rs2_read (id_rs2_read),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_d      = state_q;
    flush_rem_d  = flush_rem_q;
    err_set      = 2'b00;
    pc_stall     = 1'b0;
    pc_branch    = 1'b0;
    pc_jump      = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;

    if (mem_busy) begin
      // EX is frozen: a pending redirect and any flush window wait it out.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      state_d      = (state_q == ST_RDIR) ? ST_RDIR : ST_MWAIT;
    end else if (redirect) begin
      pc_branch   = ex_branch_taken;
      pc_jump     = !ex_branch_taken;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      err_set[0]  = ex_branch_taken && ex_jump;
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_RDIR;
        flush_rem_d = FLUSH_RELOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RDIR) begin
      // ID holds a bubble from the redirect flush, so no load-use check here.
      if_id_flush = 1'b1;
      flush_rem_d = flush_rem_q - 1'b1;
      if (flush_rem_q <= FLUSH_CNT_W'(1)) begin
        state_d = ST_RUN;
      end
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_LUSE;
    end else begin
      state_d = ST_RUN;
    end

    // Timeout is a down-counter; err[1] fires on the busy cycle that hits terminal count.
    tmo_left_d = TMO_RELOAD;
    if (mem_busy) begin
      tmo_left_d = (tmo_left_q != '0) ? tmo_left_q - 1'b1 : tmo_left_q;
      err_set[1] = (tmo_left_q == TMO_CNT_W'(1));
    end

    stall_cnt_d = pc_stall ? sat_inc32(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = (!mem_busy && redirect) ? sat_inc32(flush_cnt_q) : flush_cnt_q;
    err_d       = (err_q & ~{2{err_clr}}) | err_set;

    if (rst_act) begin
      pc_stall     = 1'b0;
      pc_branch    = 1'b0;
      pc_jump      = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_act) begin
      state_q     <= ST_RUN;
      flush_rem_q <= '0;
      tmo_left_q  <= TMO_RELOAD;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      tmo_left_q  <= tmo_left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pc_offset  = ex_branch_offset;
  assign pc_jump_pc = ex_jump_target;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=4): inputs change on the
// falling edge, Mealy strobes and registered counters are checked 1 ns later.
module tb_rv32i_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_read, id_rs2_read, ex_mem_read;
  logic        ex_branch_taken, ex_jump, mem_busy, err_clr;
  logic [31:0] ex_branch_offset, ex_jump_target;
  logic        pc_stall, pc_branch, pc_jump;
  logic [31:0] pc_offset, pc_jump_pc;
  logic        if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  err;
  logic [7:0]  s;

  int vectors = 0;
  int miscompares = 0;

  // Strobe vector: {pc_stall, pc_branch, pc_jump, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_LU   = 8'h92;
  localparam logic [7:0] S_BR   = 8'h4A;
  localparam logic [7:0] S_JMP  = 8'h2A;
  localparam logic [7:0] S_BUSY = 8'h95;
  localparam logic [7:0] S_IFF  = 8'h08;

  assign s = {pc_stall, pc_branch, pc_jump, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

  rv32i_pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_offset(ex_branch_offset),
    .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
    .mem_busy(mem_busy), .err_clr(err_clr),
    .pc_stall(pc_stall), .pc_branch(pc_branch), .pc_jump(pc_jump),
    .pc_offset(pc_offset), .pc_jump_pc(pc_jump_pc),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_read = 1'b0; id_rs2_read = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_branch_taken = 1'b0; ex_branch_offset = 32'h0;
    ex_jump = 1'b0; ex_jump_target = 32'h0;
    mem_busy = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    // Reset with conflicting stimulus present
    rst = 1'b1;
    set_idle();
    mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_jump = 1'b1;
    @(negedge clk); #1;
    chk("rst_strobes", {24'h0, s}, {24'h0, S_NONE});
    mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_jump = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("post_rst_strobes", {24'h0, s}, {24'h0, S_NONE});
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    chk("post_rst_flush_cnt", flush_cnt, 32'd0);
    chk("post_rst_err", {30'h0, err}, 32'd0);

    // Load-use on rs1
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_read = 1'b1; #1;
    chk("lu_rs1_strobes", {24'h0, s}, {24'h0, S_LU});
    tick(); #1;
    chk("lu_after_strobes", {24'h0, s}, {24'h0, S_NONE});
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // Load to x0 is not a hazard
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_read = 1'b1; #1;
    chk("x0_strobes", {24'h0, s}, {24'h0, S_NONE});

    // Load-use on rs2, then same indices with rs2 unused
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7; id_rs2_read = 1'b1; #1;
    chk("lu_rs2_strobes", {24'h0, s}, {24'h0, S_LU});
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7; #1;
    chk("no_read_strobes", {24'h0, s}, {24'h0, S_NONE});
    chk("lu_rs2_stall_cnt", stall_cnt, 32'd2);

    // Taken branch with 3-cycle IF/ID flush window
    tick(); ex_branch_taken = 1'b1; ex_branch_offset = 32'hFFFF_FFF8; #1;
    chk("br_strobes", {24'h0, s}, {24'h0, S_BR});
    chk("br_offset", pc_offset, 32'hFFFF_FFF8);
    tick(); #1;
    chk("br_flush1", {24'h0, s}, {24'h0, S_IFF});
    chk("br_flush_cnt", flush_cnt, 32'd1);
    tick(); #1;
    chk("br_flush2", {24'h0, s}, {24'h0, S_IFF});
    tick(); #1;
    chk("br_flush_done", {24'h0, s}, {24'h0, S_NONE});

    // Jump, then a branch inside the flush window restarts it
    tick(); ex_jump = 1'b1; ex_jump_target = 32'h0000_1000; #1;
    chk("jmp_strobes", {24'h0, s}, {24'h0, S_JMP});
    chk("jmp_target", pc_jump_pc, 32'h0000_1000);
    tick(); #1;
    chk("jmp_flush1", {24'h0, s}, {24'h0, S_IFF});
    chk("jmp_flush_cnt", flush_cnt, 32'd2);
    tick(); ex_branch_taken = 1'b1; ex_branch_offset = 32'h10; #1;
    chk("restart_strobes", {24'h0, s}, {24'h0, S_BR});
    tick(); #1;
    chk("restart_flush1", {24'h0, s}, {24'h0, S_IFF});
    chk("restart_flush_cnt", flush_cnt, 32'd3);
    tick(); #1;
    chk("restart_flush2", {24'h0, s}, {24'h0, S_IFF});
    tick(); #1;
    chk("restart_done", {24'h0, s}, {24'h0, S_NONE});

    // Branch + jump + load-use together: branch only, err[0]
    tick(); ex_branch_taken = 1'b1; ex_jump = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_read = 1'b1; #1;
    chk("coll_strobes", {24'h0, s}, {24'h0, S_BR});
    chk("coll_err_pre", {30'h0, err}, 32'd0);
    tick(); #1;
    chk("coll_err", {30'h0, err}, 32'd1);
    chk("coll_stall_cnt", stall_cnt, 32'd2);
    chk("coll_flush_cnt", flush_cnt, 32'd4);
    tick(); err_clr = 1'b1; #1;
    chk("clr_same_cycle_err", {30'h0, err}, 32'd1);
    tick(); #1;
    chk("clr_err", {30'h0, err}, 32'd0);
    chk("clr_strobes", {24'h0, s}, {24'h0, S_NONE});

    // Collision with err_clr in the same cycle: set wins
    tick(); ex_branch_taken = 1'b1; ex_jump = 1'b1; err_clr = 1'b1; #1;
    chk("setclr_strobes", {24'h0, s}, {24'h0, S_BR});
    tick(); err_clr = 1'b1; #1;
    chk("setclr_err", {30'h0, err}, 32'd1);
    tick(); #1;
    chk("setclr_err_cleared", {30'h0, err}, 32'd0);
    tick(); #1;
    chk("setclr_done", {24'h0, s}, {24'h0, S_NONE});

    // mem_busy for 3 cycles while a branch waits in EX
    for (int i = 0; i < 3; i++) begin
      tick(); mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_offset = 32'h20; #1;
      chk("busy_br_strobes", {24'h0, s}, {24'h0, S_BUSY});
    end
    tick(); ex_branch_taken = 1'b1; ex_branch_offset = 32'h20; #1;
    chk("busy_br_release", {24'h0, s}, {24'h0, S_BR});
    chk("busy_stall_cnt", stall_cnt, 32'd5);
    chk("busy_err", {30'h0, err}, 32'd0);

    // mem_busy inside the flush window freezes it
    tick(); mem_busy = 1'b1; #1;
    chk("rdir_busy_strobes", {24'h0, s}, {24'h0, S_BUSY});
    chk("rdir_flush_cnt", flush_cnt, 32'd6);
    tick(); #1;
    chk("rdir_resume1", {24'h0, s}, {24'h0, S_IFF});
    chk("rdir_stall_cnt", stall_cnt, 32'd6);
    tick(); #1;
    chk("rdir_resume2", {24'h0, s}, {24'h0, S_IFF});
    tick(); #1;
    chk("rdir_done", {24'h0, s}, {24'h0, S_NONE});

    // Memory timeout after 4 busy cycles, then reset mid-wait
    for (int i = 0; i < 4; i++) begin
      tick(); mem_busy = 1'b1; #1;
      chk("tmo_err_pending", {30'h0, err}, 32'd0);
    end
    tick(); mem_busy = 1'b1; #1;
    chk("tmo_err", {30'h0, err}, 32'd2);
    chk("tmo_stall_cnt", stall_cnt, 32'd10);
    tick(); mem_busy = 1'b1; rst = 1'b1; #1;
    chk("rst_mid_strobes", {24'h0, s}, {24'h0, S_NONE});
    tick(); rst = 1'b0; #1;
    chk("rst_mid_after_strobes", {24'h0, s}, {24'h0, S_NONE});
    chk("rst_mid_stall_cnt", stall_cnt, 32'd0);
    chk("rst_mid_flush_cnt", flush_cnt, 32'd0);
    chk("rst_mid_err", {30'h0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32i_pipe_ctrl.md
Name: rv32i_pipe_ctrl

Overview:
- Pipeline hazard and redirect controller for the 5-stage RV32I core.
- Generates the PC-unit control flags (stall, branch-relative update, absolute jump) and the stall/flush strobes for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, data-memory wait states and EX-stage redirects with one fixed priority.
- Keeps saturating stall/flush statistics and sticky error flags.

Parameters:
- ADDR_W, 32, instruction address width.
- FLUSH_CYCLES, 1, cycles IF/ID flush is held, counting the redirect cycle; range 1..7.
- MEM_TIMEOUT, 255, consecutive mem_busy cycles before err[1] sets; range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_rs1_read  in  1  ID instruction reads rs1
- id_rs2_read  in  1  ID instruction reads rs2
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination index of EX instruction
- ex_branch_taken  in  1  EX conditional branch resolved taken
- ex_branch_offset  in  ADDR_W  sign-extended branch offset
- ex_jump  in  1  EX instruction is JAL/JALR
- ex_jump_target  in  ADDR_W  absolute jump target
- mem_busy  in  1  data memory not ready
- err_clr  in  1  clears err
- pc_stall  out  1  PC hold
- pc_branch  out  1  PC <= PC + pc_offset
- pc_jump  out  1  PC <= pc_jump_pc
- pc_offset  out  ADDR_W  = ex_branch_offset
- pc_jump_pc  out  ADDR_W  = ex_jump_target
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  bubble IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  bubble ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- stall_cnt  out  32  saturating count of stall cycles
- flush_cnt  out  32  saturating count of redirects
- err  out  2  sticky errors: bit0 branch+jump collision, bit1 mem timeout

Behaviour:
- Control outputs are Mealy (combinational from state and inputs) and valid in the same cycle as the EX event; the PC unit samples them on the next posedge. State, counters and err are registered.
- Reset: state=RUN, timeout counter=0, flush counter=0, stall_cnt=0, flush_cnt=0, err=0.
- During reset every strobe is 0 except pc_stall, which is 0 because the PC unit's own reset dominates.
- Priority, highest first: mem_busy > redirect > load-use > normal.
- mem_busy=1:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1.
  - All flushes and pc_branch/pc_jump are 0; any redirect is deferred because EX is frozen.
  - Next state is MWAIT.
- Redirect (mem_busy=0 and ex_branch_taken|ex_jump):
  - Branch wins: pc_branch=1, pc_jump=0. Otherwise pc_jump=1.
  - Both high sets err[0] and is handled as a branch.
  - pc_stall=0, if_id_flush=1, id_ex_flush=1; no stall strobes.
  - flush_cnt increments.
  - Next state is RDIR with remaining counter = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state is RUN.
- Load-use (no mem_busy, no redirect):
  - Hazard condition: ex_mem_read & ex_rd!=0 & ((id_rs1_read & id_rs1==ex_rd) | (id_rs2_read & id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - Next state is LUSE (one cycle only); the next cycle re-evaluates normally.
- pc_stall must never be 1 in the same cycle as pc_branch or pc_jump. pc_branch and pc_jump are mutually exclusive.
- States:
  - RUN: normal issue.
  - LUSE: bubble just inserted; behaves as RUN.
  - MWAIT: behaves as RUN once mem_busy=0, then goes to RUN.
  - RDIR: if_id_flush=1 while remaining>0; decrement each cycle; go to RUN at 0.
- A new redirect in RDIR restarts the counter. mem_busy in RDIR freezes the counter, and flushes stay 0 while frozen.
- stall_cnt increments on every cycle with pc_stall=1. Both counters saturate at 0xFFFFFFFF.
- Timeout: the counter increments while mem_busy=1 and clears when mem_busy=0. err[1] sets when the counter reaches MEM_TIMEOUT.
- err_clr clears err the next cycle; a simultaneous set wins.
- Reset mid-operation: all state discarded, and all outputs are 0 in the following cycle.

Decomposition:
- Shared defines file: state encodings (RUN=0, LUSE=1, MWAIT=2, RDIR=3), ResetEnable polarity, register-index width 5, zero-register constant.
- One natural sub-module: rv32i_hazard_detect, the pure combinational load-use compare.
- Counters and the FSM stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_read=1 -> same cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle (hazard gone) all 0; stall_cnt=1.
- x0 load: ex_rd=0, id_rs1=0 -> no stall.
- Taken branch: ex_branch_taken=1, offset=0xFFFFFFF8 -> pc_branch=1, pc_offset=0xFFFFFFF8, if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt=1. With FLUSH_CYCLES=3, if_id_flush stays high 2 more cycles.
- Branch+jump+load-use together: ex_branch_taken=1, ex_jump=1, hazard present -> pc_branch=1 only, no stall, err=2'b01; err_clr -> err=0.
- mem_busy for 3 cycles during taken branch -> 4 stall strobes high and pc_branch=0 for 3 cycles; cycle 4 pc_branch=1; stall_cnt=3.
- MEM_TIMEOUT=4, mem_busy held 6 cycles -> err[1]=1 after the 4th busy cycle. rst=1 mid-wait -> next cycle all outputs 0, stall_cnt=0.
